// File: rtl/fun_fpusqr_lanes_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fun_fpusqr_lanes_if : issue/result bundle of the multi-lane FP square root |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fun_fpusqr_lanes_if #(
  parameter int LANES = 2,
  parameter int DW    = 64
);
  logic [LANES-1:0]    u_en;
  logic [12:0]         u_op;
  logic [8:0]          u_regNo;
  logic [9:0]          u_II;
  logic [LANES*DW-1:0] u_A;
  logic                fxFRT_pause;
  logic [LANES-1:0]    outEn;
  logic [9:0]          outII;
  logic [12:0]         outOp;
  logic [8:0]          FUreg;
  logic [LANES*DW-1:0] outData;
  logic [10:0]         outRaise;
  logic [3:0]          fxFRT_alten;

  modport master (
    output u_en, u_op, u_regNo, u_II, u_A,
    input  fxFRT_pause, outEn, outII, outOp, FUreg, outData, outRaise, fxFRT_alten
  );

  modport slave (
    input  u_en, u_op, u_regNo, u_II, u_A,
    output fxFRT_pause, outEn, outII, outOp, FUreg, outData, outRaise, fxFRT_alten
  );
endinterface
`default_nettype wire

// File: rtl/fun_fpusqr_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fun_fpusqr_lanes : lockstep multi-lane IEEE square root, restoring, RNE    |
// | optional macro FPUSQR_TRAP_EN gates outEn on unmasked flags.  rev 1.0      |
// +----------------------------------------------------------------------------+
module fun_fpusqr_lanes #(
  parameter int         LANES  = 2,
  parameter int         EXP_W  = 11,
  parameter int         FRAC_W = 52,
  parameter logic [1:0] INDEX  = 2'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic [31:0]       fpcsr,
  fun_fpusqr_lanes_if.slave bus
);
  localparam int DW    = 1 + EXP_W + FRAC_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int QW    = FRAC_W + 2;
  localparam int RW    = FRAC_W + 4;
  localparam int XW    = 2 * QW;
  localparam int CNT_W = $clog2(FRAC_W + 2) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(FRAC_W + 1);
  localparam logic [DW-1:0]    QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [LANES-1:0] mask;
  logic [12:0]      op;
  logic [8:0]       regno;
  logic [9:0]       ii;
  logic [LANES-1:0] lane_inv, lane_inx;
  logic             accept, done, flag_inv, flag_inx, trap;

  assign accept = (state == IDLE) && (|bus.u_en) && !except;
  assign done   = (state == DONE) && !except;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ITER) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = NORM;
      NORM:    state_nx = except ? IDLE : ITER;
      ITER:    state_nx = except ? IDLE : ((cnt == LAST_ITER) ? ROUND : ITER);
      ROUND:   state_nx = except ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= '0;
      op    <= '0;
      regno <= '0;
      ii    <= '0;
    end else if (accept) begin
      mask  <= bus.u_en;
      op    <= bus.u_op;
      regno <= bus.u_regNo;
      ii    <= bus.u_II;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0]           a, sval, res, n_sval;
    logic                    sgn, odd, n_spec, n_inv;
    logic [EXP_W-1:0]        e, n_rexp, rexp;
    logic [FRAC_W-1:0]       f;
    logic signed [EXP_W+1:0] e_unb, e_adj;
    logic [XW-1:0]           n_x, xs;
    logic [RW-1:0]           rem, rem_sh, trial;
    logic [QW-1:0]           root;
    logic                    spec, sinv, rinv, rinx, ge, guard, sticky, up;

    always_comb begin
      {sgn, e, f} = a;
      // Unbiased exponent made even; an odd one moves a factor of two into the radicand.
      e_unb  = $signed({2'b00, e}) - $signed((EXP_W+2)'(BIAS));
      odd    = e_unb[0];
      e_adj  = e_unb - $signed({{(EXP_W+1){1'b0}}, odd});
      n_rexp = EXP_W'((e_adj >>> 1) + $signed((EXP_W+2)'(BIAS)));
      n_x    = odd ? {1'b1, f, 1'b0, {QW{1'b0}}} : {2'b01, f, {QW{1'b0}}};

      n_spec = 1'b1;
      n_inv  = 1'b0;
      n_sval = '0;
      if (e == '0)
        n_sval = {sgn, {(DW-1){1'b0}}};
      else if (e == '1 && f != '0)
        n_sval = {sgn, {EXP_W{1'b1}}, 1'b1, f[FRAC_W-2:0]};
      else if (sgn) begin
        n_sval = QNAN;
        n_inv  = 1'b1;
      end else if (e == '1)
        n_sval = a;
      else
        n_spec = 1'b0;

      rem_sh = {rem[RW-3:0], xs[XW-1 -: 2]};
      trial  = {root, 2'b01};
      ge     = (rem_sh >= trial);
      guard  = root[0];
      sticky = |rem;
      up     = guard & (sticky | root[1]);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a    <= '0;
        sval <= '0;
        res  <= '0;
        rexp <= '0;
        xs   <= '0;
        rem  <= '0;
        root <= '0;
        spec <= 1'b0;
        sinv <= 1'b0;
        rinv <= 1'b0;
        rinx <= 1'b0;
      end else begin
        if (accept) a <= bus.u_A[k*DW +: DW];
        case (state)
          NORM: begin
            spec <= n_spec;
            sval <= n_sval;
            sinv <= n_inv;
            rexp <= n_rexp;
            xs   <= n_x;
            rem  <= '0;
            root <= '0;
          end
          ITER: begin
            xs <= xs << 2;
            if (ge) begin
              rem  <= rem_sh - trial;
              root <= {root[QW-2:0], 1'b1};
            end else begin
              rem  <= rem_sh;
              root <= {root[QW-2:0], 1'b0};
            end
          end
          ROUND: begin
            if (!mask[k]) begin
              res  <= '0;
              rinv <= 1'b0;
              rinx <= 1'b0;
            end else if (spec) begin
              res  <= sval;
              rinv <= sinv;
              rinx <= 1'b0;
            end else begin
              // A carry out of the fraction lands in the exponent field naturally.
              res  <= {1'b0, rexp, root[QW-2:1]} + DW'(up);
              rinv <= 1'b0;
              rinx <= guard | sticky;
            end
          end
          default: ;
        endcase
      end
    end

    assign lane_inv[k]              = rinv;
    assign lane_inx[k]              = rinx;
    assign bus.outData[k*DW +: DW]  = done ? res : '0;
  end

  assign flag_inv = |lane_inv;
  assign flag_inx = |lane_inx;

`ifdef FPUSQR_TRAP_EN
  logic unused_fpcsr;
  assign unused_fpcsr = ^{fpcsr[31:5], fpcsr[3:1]};
  assign trap         = (flag_inv & ~fpcsr[0]) | (flag_inx & ~fpcsr[4]);
`else
  logic unused_fpcsr;
  assign unused_fpcsr = ^fpcsr;
  assign trap         = 1'b0;
`endif

  assign bus.fxFRT_pause = (state != IDLE);
  assign bus.outEn       = (done && !trap) ? mask : '0;
  assign bus.outII       = ii;
  assign bus.outOp       = op;
  assign bus.FUreg       = regno;
  assign bus.outRaise    = done ? {6'b0, flag_inx, 3'b0, flag_inv} : 11'b0;
  assign bus.fxFRT_alten = done ? (4'b0001 << INDEX) : 4'b0000;
endmodule
`default_nettype wire
